// File: rtl/sad_best_match_pkg.sv
// rtl/sad_best_match_pkg.sv - shared motion-estimation types and constants
// Purpose: search FSM state enum, default SAD width and the all-ones SAD seed.
// Ports: none (package).
package sad_best_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // 4x8 block of 8-bit pixels: 8 bits + log2(32) growth.
  localparam int SAD_WIDTH_DEF = 13;

  // Wide enough for any practical SAD width; users truncate to their width.
  localparam logic [31:0] SAD_ONES = '1;

endpackage

// File: rtl/sad_best_match_if.sv
// rtl/sad_best_match_if.sv - sequencer/SAD-side bus of the best-match controller
// Purpose: groups the start/sample inputs and the status/result outputs.
// Ports (master = sequencer, slave = controller):
//   start, sad_valid, sad_in           master -> slave
//   busy, done, best_sad, best_idx,
//   cand_count                         slave -> master
interface sad_best_match_if #(
  parameter int SAD_WIDTH = 13,
  parameter int IDX_WIDTH = 6
);

  logic                 start;
  logic                 sad_valid;
  logic [SAD_WIDTH-1:0] sad_in;
  logic                 busy;
  logic                 done;
  logic [SAD_WIDTH-1:0] best_sad;
  logic [IDX_WIDTH-1:0] best_idx;
  logic [IDX_WIDTH:0]   cand_count;

  modport master (
    output start, sad_valid, sad_in,
    input  busy, done, best_sad, best_idx, cand_count
  );

  modport slave (
    input  start, sad_valid, sad_in,
    output busy, done, best_sad, best_idx, cand_count
  );

endinterface

// File: rtl/sad_best_match_sad_min_cmp.sv
// rtl/sad_best_match_sad_min_cmp.sv - combinational compare-and-select of the running minimum
// Purpose: picks the next (best_sad, best_idx) pair and flags a zero SAD.
// Ports:
//   best_sad, best_idx  in   current running minimum and its index
//   sad_in, index       in   candidate SAD and its index
//   first               in   candidate is the first of the window; always taken
//   next_sad, next_idx  out  updated minimum pair
//   is_zero             out  sad_in is a perfect match
module sad_min_cmp
  import sad_best_match_pkg::*;
#(
  parameter int SAD_WIDTH = SAD_WIDTH_DEF,
  parameter int IDX_WIDTH = 6
) (
  input  logic [SAD_WIDTH-1:0] best_sad,
  input  logic [IDX_WIDTH-1:0] best_idx,
  input  logic [SAD_WIDTH-1:0] sad_in,
  input  logic [IDX_WIDTH-1:0] index,
  input  logic                 first,
  output logic [SAD_WIDTH-1:0] next_sad,
  output logic [IDX_WIDTH-1:0] next_idx,
  output logic                 is_zero
);

  logic take;

  // Strict less-than keeps the earliest candidate on ties; the first sample
  // is forced so an all-ones SAD still replaces the all-ones seed.
  assign take     = first || (sad_in < best_sad);
  assign next_sad = take ? sad_in : best_sad;
  assign next_idx = take ? index  : best_idx;
  assign is_zero  = (sad_in == '0);

endmodule

// File: rtl/sad_best_match.sv
// rtl/sad_best_match.sv - motion-estimation best-match search controller
// Purpose: tracks the minimum SAD and its candidate index over a search window,
//          finishing on the last candidate or on a zero SAD.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   sad_best_match_if.slave: start/sad_valid/sad_in in;
//         busy/done/best_sad/best_idx/cand_count out
module sad_best_match
  import sad_best_match_pkg::*;
#(
  parameter int SAD_WIDTH = SAD_WIDTH_DEF,
  parameter int NUM_CAND  = 64,
  parameter int IDX_WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  sad_best_match_if.slave  bus
);

  localparam logic [SAD_WIDTH-1:0] SAD_INIT = SAD_ONES[SAD_WIDTH-1:0];
  localparam logic [IDX_WIDTH:0]   LAST_CNT = (IDX_WIDTH+1)'(NUM_CAND - 1);
  localparam logic [IDX_WIDTH:0]   CNT_ONE  = (IDX_WIDTH+1)'(1);

  state_t               state;
  logic                 busy_q;
  logic                 done_q;
  logic [SAD_WIDTH-1:0] best_sad_q;
  logic [IDX_WIDTH-1:0] best_idx_q;
  logic [IDX_WIDTH:0]   cnt_q;

  logic [SAD_WIDTH-1:0] next_sad;
  logic [IDX_WIDTH-1:0] next_idx;
  logic                 is_zero;

  sad_min_cmp #(
    .SAD_WIDTH (SAD_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_cmp (
    .best_sad (best_sad_q),
    .best_idx (best_idx_q),
    .sad_in   (bus.sad_in),
    .index    (cnt_q[IDX_WIDTH-1:0]),
    .first    (cnt_q == '0),
    .next_sad (next_sad),
    .next_idx (next_idx),
    .is_zero  (is_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      best_sad_q <= SAD_INIT;
      best_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state      <= ST_SEARCH;
            busy_q     <= 1'b1;
            best_sad_q <= SAD_INIT;
            best_idx_q <= '0;
            cnt_q      <= '0;
          end
        end
        ST_SEARCH: begin
          if (bus.sad_valid) begin
            best_sad_q <= next_sad;
            best_idx_q <= next_idx;
            cnt_q      <= cnt_q + CNT_ONE;
            // The final sample's update lands on the same edge as the exit.
            if (cnt_q == LAST_CNT || is_zero) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.best_sad   = best_sad_q;
  assign bus.best_idx   = best_idx_q;
  assign bus.cand_count = cnt_q;

endmodule

// File: tb/tb_sad_best_match.sv
// tb/tb_sad_best_match.sv - directed self-checking bench for sad_best_match
module tb_sad_best_match;

  localparam int SW = 13;
  localparam int NC = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sad_best_match_if #(.SAD_WIDTH(SW), .IDX_WIDTH(IW)) bus ();

  sad_best_match #(
    .SAD_WIDTH (SW),
    .NUM_CAND  (NC),
    .IDX_WIDTH (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic begin_search();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic sample(input int v);
    bus.sad_valid = 1'b1;
    bus.sad_in    = SW'(v);
    tick();
    bus.sad_valid = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int d, input int s, input int i, input int c);
    chk({tag, "_done"}, 32'(bus.done), 32'(d));
    chk({tag, "_sad"},  32'(bus.best_sad), 32'(s));
    chk({tag, "_idx"},  32'(bus.best_idx), 32'(i));
    chk({tag, "_cnt"},  32'(bus.cand_count), 32'(c));
  endtask

  initial begin
    int gap_vals [4];
    gap_vals = '{9, 7, 8, 3};
    bus.start     = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad_in    = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk_result("rst", 0, 8191, 0, 0);

    // Sequential window with a tie
    begin_search();
    chk("seq_busy", 32'(bus.busy), 1);
    sample(40);
    sample(25);
    sample(30);
    chk("seq_nodone", 32'(bus.done), 0);
    sample(25);
    chk("seq_busy_end", 32'(bus.busy), 0);
    chk_result("seq", 1, 25, 1, 4);
    tick();
    chk("seq_done_clr", 32'(bus.done), 0);

    // Early exit on zero; the third sample is offered and must be ignored
    begin_search();
    sample(50);
    sample(0);
    chk_result("early", 1, 0, 1, 2);
    sample(10);
    chk_result("early_ign", 0, 0, 1, 2);
    chk("early_busy", 32'(bus.busy), 0);

    // Gapped valid
    begin_search();
    for (int k = 0; k < 4; k++) begin
      sample(gap_vals[k]);
      if (k < 3) begin
        chk($sformatf("gap_nodone%0d", k), 32'(bus.done), 0);
        tick();
        tick();
      end
    end
    chk_result("gap", 1, 3, 3, 4);
    tick();

    // start during SEARCH and DONE is ignored
    begin_search();
    sample(20);
    bus.start = 1'b1;
    sample(10);
    bus.start = 1'b0;
    chk("ss_cnt", 32'(bus.cand_count), 2);
    chk("ss_sad", 32'(bus.best_sad), 10);
    sample(15);
    sample(5);
    chk_result("ss", 1, 5, 3, 4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("sd_busy", 32'(bus.busy), 0);
    chk_result("sd", 0, 5, 3, 4);
    bus.sad_valid = 1'b1;
    bus.sad_in    = SW'(1);
    tick();
    tick();
    bus.sad_valid = 1'b0;
    chk_result("idle_valid", 0, 5, 3, 4);

    // Reset mid-search, then a fresh search
    begin_search();
    sample(12);
    sample(6);
    rst = 1'b1;
    bus.sad_valid = 1'b1;
    bus.sad_in    = SW'(2);
    tick();
    rst = 1'b0;
    bus.sad_valid = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk_result("abort", 0, 8191, 0, 0);
    tick();
    chk("abort_nodone", 32'(bus.done), 0);
    begin_search();
    sample(7);
    sample(9);
    sample(2);
    sample(5);
    chk_result("fresh", 1, 2, 2, 4);
    tick();

    // All samples at the maximum value
    begin_search();
    for (int k = 0; k < 4; k++) sample(8191);
    chk_result("max", 1, 8191, 0, 4);
    tick();
    chk("max_done_clr", 32'(bus.done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sad_best_match.md
# sad_best_match

Motion-estimation search controller that sits directly downstream of the 4x8 SAD datapath. It consumes one SAD value per candidate block over a search window and tracks the minimum SAD together with the index of the candidate that produced it. When the window is exhausted, or when a perfect match (SAD = 0) arrives, it reports the winning index as the block's motion-vector result. One search runs at a time; the controller is started by the motion-estimation sequencer.

## Interface
Parameters:
- SAD_WIDTH, default 13: width of incoming SAD values; matches the SAD datapath output (WIDTH+5 for 8-bit pixels).
- NUM_CAND, default 64: number of candidates per search window; must be ≥ 2.
- IDX_WIDTH, default 6: candidate index width; must satisfy 2^IDX_WIDTH ≥ NUM_CAND.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begins a new search; honoured only in IDLE.
- sad_valid  in  1  sad_in carries a valid candidate SAD this cycle.
- sad_in  in  SAD_WIDTH  SAD of the current candidate; candidates arrive in index order 0..NUM_CAND-1.
- busy  out  1  high while in SEARCH.
- done  out  1  one-cycle pulse; result outputs are valid.
- best_sad  out  SAD_WIDTH  minimum SAD of the last completed search.
- best_idx  out  IDX_WIDTH  index of the candidate that produced best_sad.
- cand_count  out  IDX_WIDTH+1  number of samples accepted in the current or last search.

## Operation
- FSM has three states: IDLE, SEARCH, DONE.
- IDLE → SEARCH on start. The same edge loads best_sad to all-ones, best_idx to 0 and cand_count to 0.
- SEARCH: each sad_valid sample is accepted with index = cand_count.
  - Update rule: if sad_in < best_sad (strict), load best_sad ← sad_in and best_idx ← index. On ties the earliest candidate wins.
  - cand_count increments by 1 per accepted sample.
- SEARCH → DONE on an accepted sample when either:
  - index == NUM_CAND-1 (window exhausted), or
  - sad_in == 0 (early exit).
  - The update of that final sample takes effect on the same edge as the transition.
- DONE → IDLE unconditionally after one cycle. done is decoded from state (Moore) and is 1 only in DONE.
- best_sad, best_idx and cand_count hold their values from the end of DONE until the next start.
- Ignored inputs:
  - start in SEARCH or DONE is ignored.
  - sad_valid in IDLE or DONE is ignored; no counter or result change.
- Arithmetic is unsigned compare only; there is no accumulation, so overflow cannot occur.
- Initial all-ones best_sad guarantees the first sample always loads, including a sample equal to all-ones. To achieve this, the first sample (cand_count == 0) loads unconditionally.

## Timing
- Reset values: state IDLE, busy 0, done 0, best_sad all-ones, best_idx 0, cand_count 0.
- rst mid-search aborts the search. No done pulse is produced, and all registers return to their reset values on that edge.
- start sampled at edge N: busy = 1 from cycle N+1. The first sample can be accepted at edge N+1.
- Final sample accepted at edge M: done = 1 and results valid during cycle M+1. busy = 0 from cycle M+1; the FSM is in IDLE at cycle M+2.
- A new start is honoured at the earliest at edge M+2.
- Throughput: one candidate per cycle with no bubbles. sad_valid may toggle arbitrarily; gaps only stall counting.
- The SAD datapath pipeline latency is absorbed upstream. This block relies solely on sad_valid alignment.

## Structure
- Shared motion-estimation package contains:
  - the state enum (IDLE, SEARCH, DONE);
  - the default SAD_WIDTH constant;
  - the all-ones SAD initial constant.
- One sub-module, sad_min_cmp: a combinational compare-and-select taking (best_sad, best_idx, sad_in, index, first). It returns the next best pair and a zero-detect flag.
- The FSM, counter and result registers remain in the top module.

## Test plan
- Sequential window, NUM_CAND=4, samples 40, 25, 30, 25 → done one cycle after the 4th sample; best_sad = 25, best_idx = 1 (tie keeps earliest); cand_count = 4.
- Early exit, samples 50, 0, then 10 offered → done after the 2nd sample; best_sad = 0, best_idx = 1, cand_count = 2. The third sample is ignored.
- Gapped valid: samples 9, 7, 8, 3 with 2-cycle gaps between them → best_sad = 3, best_idx = 3; done follows the last sample by exactly 1 cycle.
- start asserted during SEARCH and during DONE → no restart, results unchanged. sad_valid pulses in IDLE leave cand_count and results untouched.
- rst asserted after 2 of 4 samples → no done pulse; all outputs return to reset values (best_sad = 8191 for SAD_WIDTH = 13). A fresh search then completes normally.
- Max-value sample: first sample 8191, remaining samples also 8191 → best_idx = 0, best_sad = 8191.
